id_entry: RTL

Keypad front end of the access machine. It debounces the raw key strobe and assembles a fixed-length decimal ID from digit keys. When the user confirms a complete ID, it raises `id_typed`, which the session timer (ID-entry / exhibition timeout stage) consumes directly downstream. The block aborts and clears itself when that timer reports an ID-entry timeout (`time_max_id`) or when the main FSM leaves the ID phase.

---
 rtl/id_entry.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/id_entry.sv
// Keypad front end: synchronizes and debounces the raw key strobe, then
// assembles a fixed-length BCD ID and raises id_typed once it is confirmed.
module id_entry #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         key_press,
  input  logic [3:0]                   key_code,
  input  logic                         time_max_id,
  output logic                         id_typed,
  output logic [4*DIGITS-1:0]          id_value,
  output logic [$clog2(DIGITS+1)-1:0]  digit_count,
  output logic                         entry_error
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int NW = $clog2(DIGITS + 1);
  localparam int IW = 4 * DIGITS;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [NW-1:0] FULL     = NW'(DIGITS);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  logic          press_s1_q, press_s2_q;
  logic [3:0]    code_s1_q, code_s2_q;
  logic [1:0]    settle_q, settle_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          db_q, db_d;
  logic          arm_q, arm_d;
  logic          evt_q, evt_d;
  logic [3:0]    evt_code_q, evt_code_d;
  state_t        state_q;

  // Synchronizer stage
  always_ff @(posedge clk) begin
    if (rst) begin
      press_s1_q <= 1'b0;
      press_s2_q <= 1'b0;
      code_s1_q  <= 4'h0;
      code_s2_q  <= 4'h0;
    end else begin
      press_s1_q <= key_press;
      press_s2_q <= press_s1_q;
      code_s1_q  <= key_code;
      code_s2_q  <= code_s1_q;
    end
  end

  // Debounce stage. The arm flag keeps a key already held through reset from
  // producing an event: it is set only once the settled synced level is seen low.
  always_comb begin
    cnt_d      = cnt_q;
    db_d       = db_q;
    arm_d      = arm_q;
    evt_d      = 1'b0;
    evt_code_d = evt_code_q;
    settle_d   = {settle_q[0], 1'b1};
    if (press_s2_q == db_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d      = '0;
      db_d       = ~db_q;
      evt_d      = ~db_q & arm_q;
      evt_code_d = code_s2_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
    if (settle_q[1] && !press_s2_q && !db_q)
      arm_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_q   <= 2'b00;
      cnt_q      <= '0;
      db_q       <= 1'b0;
      arm_q      <= 1'b0;
      evt_q      <= 1'b0;
      evt_code_q <= 4'h0;
    end else begin
      settle_q   <= settle_d;
      cnt_q      <= cnt_d;
      db_q       <= db_d;
      arm_q      <= arm_d;
      evt_q      <= evt_d;
      evt_code_q <= evt_code_d;
    end
  end

  // Entry FSM stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      id_typed    <= 1'b0;
      id_value    <= '0;
      digit_count <= '0;
      entry_error <= 1'b0;
    end else begin
      entry_error <= 1'b0;
      if (!enable || (time_max_id && state_q != IDLE)) begin
        state_q     <= IDLE;
        id_typed    <= 1'b0;
        id_value    <= '0;
        digit_count <= '0;
      end else begin
        case (state_q)
          IDLE: state_q <= COLLECT;
          COLLECT: begin
            if (evt_q) begin
              if (evt_code_q <= 4'd9) begin
                if (digit_count != FULL) begin
                  id_value    <= (id_value << 4) | IW'(evt_code_q);
                  digit_count <= digit_count + NW'(1);
                end else begin
                  entry_error <= 1'b1;
                end
              end else if (evt_code_q == 4'hA) begin
                id_value    <= '0;
                digit_count <= '0;
              end else if (evt_code_q == 4'hB) begin
                if (digit_count == FULL) begin
                  state_q  <= DONE;
                  id_typed <= 1'b1;
                end else begin
                  entry_error <= 1'b1;
                end
              end
            end
          end
          DONE:    state_q <= DONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
